// File: rtl/reg_write_bank.sv
// rtl/reg_write_bank.sv - register write bank with per-register increment and a one-cycle data-memory write strobe
// Optional AC_ZERO_FLAG_EN adds the registered ac zero flag output z_flag.
module reg_write_bank (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  write_en,
  input  logic [15:0] bus_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  inc_sel,
  output logic [7:0]  pc,
  output logic [7:0]  dr,
  output logic [7:0]  r,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [7:0]  r3,
  output logic [7:0]  ri,
  output logic [7:0]  rj,
  output logic [7:0]  rk,
  output logic [7:0]  ra,
  output logic [7:0]  rb,
  output logic [15:0] ac,
  output logic [15:0] tr,
  output logic        dm_we,
  output logic [7:0]  dm_wdata
`ifdef AC_ZERO_FLAG_EN
  , output logic      z_flag
`endif
);

  typedef enum logic {IDLE, DM_BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, dr_q, r_q, r1_q, r2_q, r3_q, ri_q, rj_q, rk_q, ra_q, rb_q;
  logic [7:0]  pc_d, dr_d, r_d, r1_d, r2_d, r3_d, ri_d, rj_d, rk_d, ra_d, rb_d;
  logic [15:0] ac_q, tr_q, ac_d, tr_d;
  logic [7:0]  dm_wdata_q, dm_wdata_d;
  logic        accept;
  logic        ac_touched;

  assign wr_ready = (state_q == IDLE);
  assign accept   = wr_valid && wr_ready;
  assign dm_we    = (state_q == DM_BUSY);

  always_comb begin
    state_d    = IDLE;
    pc_d = pc_q; dr_d = dr_q; r_d  = r_q;  r1_d = r1_q; r2_d = r2_q; r3_d = r3_q;
    ri_d = ri_q; rj_d = rj_q; rk_d = rk_q; ra_d = ra_q; rb_d = rb_q;
    ac_d       = ac_q;
    tr_d       = tr_q;
    dm_wdata_d = dm_wdata_q;
    ac_touched = 1'b0;

    // Increments first so that a same-register write below overrides them.
    case (inc_sel)
      3'd1: pc_d = pc_q + 8'd1;
      3'd2: ri_d = ri_q + 8'd1;
      3'd3: rj_d = rj_q + 8'd1;
      3'd4: rk_d = rk_q + 8'd1;
      3'd5: begin ac_d = ac_q + 16'd1; ac_touched = 1'b1; end
      default: ;
    endcase

    if (accept) begin
      case (write_en)
        4'd1:  begin dm_wdata_d = bus_in[7:0]; state_d = DM_BUSY; end
        4'd2:  pc_d = bus_in[7:0];
        4'd3:  dr_d = bus_in[7:0];
        4'd4:  r_d  = bus_in[7:0];
        4'd5:  begin ac_d = bus_in; ac_touched = 1'b1; end
        4'd6:  tr_d = bus_in;
        4'd7:  r1_d = bus_in[7:0];
        4'd8:  r2_d = bus_in[7:0];
        4'd9:  ri_d = bus_in[7:0];
        4'd10: rj_d = bus_in[7:0];
        4'd11: rk_d = bus_in[7:0];
        4'd12: r3_d = bus_in[7:0];
        4'd13: ra_d = bus_in[7:0];
        4'd14: rb_d = bus_in[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0; dr_q <= '0; r_q  <= '0; r1_q <= '0; r2_q <= '0; r3_q <= '0;
      ri_q <= '0; rj_q <= '0; rk_q <= '0; ra_q <= '0; rb_q <= '0;
      ac_q <= '0; tr_q <= '0; dm_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d; dr_q <= dr_d; r_q  <= r_d;  r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
      ri_q <= ri_d; rj_q <= rj_d; rk_q <= rk_d; ra_q <= ra_d; rb_q <= rb_d;
      ac_q <= ac_d; tr_q <= tr_d; dm_wdata_q <= dm_wdata_d;
    end
  end

`ifdef AC_ZERO_FLAG_EN
  logic z_q, z_d;

  always_comb begin
    z_d = z_q;
    if (ac_touched) z_d = (ac_d == 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= 1'b1;
    else        z_q <= z_d;
  end

  assign z_flag = z_q;
`else
  logic unused_ac_touched;
  assign unused_ac_touched = ac_touched;
`endif

  assign pc = pc_q; assign dr = dr_q; assign r  = r_q;  assign r1 = r1_q;
  assign r2 = r2_q; assign r3 = r3_q; assign ri = ri_q; assign rj = rj_q;
  assign rk = rk_q; assign ra = ra_q; assign rb = rb_q;
  assign ac = ac_q; assign tr = tr_q;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: doc/reg_write_bank.md
REG_WRITE_BANK -- requirements
Module: reg_write_bank

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port write_en, input, 4, destination code: 1 dm, 2 pc, 3 dr, 4 r, 5 ac, 6 tr, 7 r1, 8 r2, 9 ri, 10 rj, 11 rk, 12 r3, 13 ra, 14 rb; 0 (im) and 15 are no destination.
REQ-004 SHALL have port bus_in, input, 16, bus value to be written.
REQ-005 SHALL have port wr_valid, input, 1, write request qualifier.
REQ-006 SHALL have port wr_ready, output, 1, bank can accept a write this cycle.
REQ-007 SHALL have port inc_sel, input, 3, increment select: 0 none, 1 pc, 2 ri, 3 rj, 4 rk, 5 ac, 6-7 none.
REQ-008 SHALL have ports pc, dr, r, r1, r2, r3, ri, rj, rk, ra, rb, output, 8 each, register contents.
REQ-009 SHALL have ports ac and tr, output, 16 each, register contents.
REQ-010 SHALL have ports dm_we (output, 1, data-memory write strobe) and dm_wdata (output, 8, data-memory write data).

Function
REQ-011 SHALL accept a write on a rising edge where wr_valid and wr_ready are both 1; otherwise no register changes due to write_en.
REQ-012 SHALL load bus_in[7:0] into 8-bit destinations and bus_in[15:0] into ac/tr on acceptance; result visible the cycle after acceptance.
REQ-013 SHALL treat codes 0 and 15 as accepted no-ops: wr_ready stays 1, no state change.
REQ-014 SHALL implement FSM IDLE and DM_BUSY; IDLE->DM_BUSY on accepted code-1 write; DM_BUSY->IDLE unconditionally after one cycle.
REQ-015 SHALL assert dm_we for exactly the one cycle in DM_BUSY, with dm_wdata holding the accepted bus_in[7:0]; dm_wdata holds its last value otherwise.
REQ-016 SHALL drive wr_ready = 1 in IDLE and 0 in DM_BUSY (combinational from state).
REQ-017 SHALL increment the inc_sel target by 1 each rising edge, independent of wr_valid/wr_ready and FSM state.
REQ-018 SHALL wrap increments modulo 2^8 for 8-bit registers (8'hFF -> 8'h00) and modulo 2^16 for ac (16'hFFFF -> 16'h0000).
REQ-019 SHALL give an accepted write priority over an increment to the same register in the same cycle; increment is discarded.
REQ-020 SHALL apply a write and an increment to different registers in the same cycle concurrently.

Reset
REQ-021 SHALL on rst_n = 0 immediately clear all register outputs to 0, dm_we to 0, dm_wdata to 0, and FSM to IDLE (wr_ready = 1), independent of clk.
REQ-022 SHALL abort a pending DM_BUSY cycle if reset asserts during it; no dm_we pulse after reset release.
REQ-023 SHALL accept the first write on the first rising edge with rst_n = 1.

Configuration
REQ-024 SHALL, with AC_ZERO_FLAG_EN defined, provide output z_flag (1 bit) registered as 1 when the next ac value is 16'h0000, reset value 1, updated every cycle ac is written or incremented.
REQ-025 SHALL, without AC_ZERO_FLAG_EN, omit z_flag port and logic entirely; all other behaviour identical.

Verification
REQ-026 SHALL cover: reset release, write_en=5, bus_in=16'hA5C3, wr_valid=1 -> ac=16'hA5C3 next cycle, tr=0, wr_ready stays 1.
REQ-027 SHALL cover: write_en=3, bus_in=16'h12F7 -> dr=8'hF7; write_en=6 same bus -> tr=16'h12F7.
REQ-028 SHALL cover: write_en=1, bus_in=16'h0042 -> next cycle dm_we=1, dm_wdata=8'h42, wr_ready=0; a write_en=7 request that cycle is not accepted (r1 unchanged); following cycle wr_ready=1, dm_we=0.
REQ-029 SHALL cover: pc=8'hFF, inc_sel=1 -> pc=8'h00; ac=16'hFFFF, inc_sel=5 -> ac=16'h0000 (z_flag=1 when AC_ZERO_FLAG_EN).
REQ-030 SHALL cover: ri=8'h10, inc_sel=2 with write_en=9, bus_in=16'h0033 same cycle -> ri=8'h33; with write_en=10 instead -> ri=8'h11, rj=8'h33.
REQ-031 SHALL cover: rst_n pulsed low mid-cycle while in DM_BUSY -> all outputs 0 asynchronously, no dm_we after release.
